// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared types and constants for the PC sequencer: next-PC
//                source select encoding, PC increment and default vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  // Which source feeds the PC register on the next edge.
  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_J    = 3'd2,
    SEL_JR   = 3'd3,
    SEL_RET  = 3'd4,
    SEL_EXC  = 3'd5,
    SEL_HOLD = 3'd6
  } next_sel_t;

  localparam int unsigned PC_INC               = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Control/status bundle between decode/execute and the PC
//                sequencer.
//                master : drives stall/branch/jump/jr/call/ret/exc controls,
//                         observes pc, pc_plus4, epc, RAS flags and pulses.
//                slave  : the sequencer itself (opposite directions).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             br_taken;
  logic [15:0]      br_offset;
  logic             jump;
  logic [25:0]      jump_target;
  logic             jr;
  logic [WIDTH-1:0] jr_addr;
  logic             call;
  logic             ret;
  logic             exc;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] epc;
  logic             ras_empty;
  logic             ras_full;
  logic             ret_miss;
  logic             align_err;

  modport master (
    output stall, br_taken, br_offset, jump, jump_target, jr, jr_addr,
           call, ret, exc,
    input  pc, pc_plus4, epc, ras_empty, ras_full, ret_miss, align_err
  );

  modport slave (
    input  stall, br_taken, br_offset, jump, jump_target, jr, jr_addr,
           call, ret, exc,
    output pc, pc_plus4, epc, ras_empty, ras_full, ret_miss, align_err
  );

endinterface : pc_sequencer_if
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : Circular return-address stack. A push while full overwrites
//                the oldest entry (count saturates); a pop while empty is
//                ignored. Push and pop are never asserted together.
//  Ports       : clk, rst (sync, active-low), push, pop, push_data,
//                top (newest entry), count, empty, full
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] push_data,
  output logic      [WIDTH-1:0] top,
  output logic      [AW:0]      count,
  output logic                  empty,
  output logic                  full
);

  localparam logic [AW-1:0] c_ptr_one = AW'(1);
  localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
  localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_ptr;    // next write slot; newest entry sits at r_ptr-1
  logic [AW:0]      r_count;

  // Entry storage needs no reset: it is only read when count is nonzero.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      r_mem[r_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_ptr <= r_ptr + c_ptr_one;
      if (r_count != c_depth) begin
        r_count <= r_count + c_cnt_one;
      end
    end else if (pop && (r_count != '0)) begin
      r_ptr   <= r_ptr - c_ptr_one;
      r_count <= r_count - c_cnt_one;
    end
  end

  assign top   = r_mem[r_ptr - c_ptr_one];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == c_depth);

endmodule : ras_stack
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Fetch program counter with prioritised next-PC selection
//                (exception > stall > return > jr > jump > branch > seq),
//                return-address stack and exception PC capture.
//  Ports       : clk, rst (sync, active-low),
//                bus (pc_sequencer_if.slave): controls in, pc/pc_plus4/epc,
//                RAS empty/full flags and ret_miss/align_err pulses out.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int               RAS_DEPTH    = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  pc_sequencer_if.slave  bus
);

  localparam int             c_ras_aw = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] c_inc  = WIDTH'(PC_INC);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic             r_ret_miss;
  logic             r_align_err;

  next_sel_t        w_sel;
  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_br_target;
  logic [WIDTH-1:0] w_j_target;
  logic [WIDTH-1:0] w_jr_target;
  logic [WIDTH-1:0] w_next_pc;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_ras_top;
  logic [c_ras_aw:0] w_ras_count;
  logic             w_ras_empty;
  logic             w_ras_full;

  assign w_pc_plus4  = r_pc + c_inc;
  assign w_br_target = w_pc_plus4 +
                       {{(WIDTH-18){bus.br_offset[15]}}, bus.br_offset, 2'b00};
  assign w_j_target  = {w_pc_plus4[WIDTH-1:28], bus.jump_target, 2'b00};
  assign w_jr_target = {bus.jr_addr[WIDTH-1:2], 2'b00};

  always_comb begin
    w_sel = SEL_SEQ;
    if (bus.exc) begin
      w_sel = SEL_EXC;
    end else if (bus.stall) begin
      w_sel = SEL_HOLD;
    end else if (bus.ret) begin
      w_sel = SEL_RET;
    end else if (bus.jr) begin
      w_sel = SEL_JR;
    end else if (bus.jump) begin
      w_sel = SEL_J;
    end else if (bus.br_taken) begin
      w_sel = SEL_BR;
    end
  end

  // call only qualifies jump/jr; ret outranks both so ret+call never pushes.
  assign w_push = bus.call && ((w_sel == SEL_J) || (w_sel == SEL_JR));
  assign w_pop  = (w_sel == SEL_RET);

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (w_sel)
      SEL_EXC:  w_next_pc = EXC_VECTOR;
      SEL_HOLD: w_next_pc = r_pc;
      SEL_RET:  w_next_pc = w_ras_empty ? w_pc_plus4 : w_ras_top;
      SEL_JR:   w_next_pc = w_jr_target;
      SEL_J:    w_next_pc = w_j_target;
      SEL_BR:   w_next_pc = w_br_target;
      default:  w_next_pc = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc        <= RESET_VECTOR;
      r_epc       <= '0;
      r_ret_miss  <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_pc        <= w_next_pc;
      r_ret_miss  <= (w_sel == SEL_RET) && w_ras_empty;
      r_align_err <= (w_sel == SEL_JR) && (bus.jr_addr[1:0] != 2'b00);
      if (w_sel == SEL_EXC) begin
        r_epc <= r_pc;
      end
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (WIDTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_plus4),
    .top       (w_ras_top),
    .count     (w_ras_count),
    .empty     (w_ras_empty),
    .full      (w_ras_full)
  );

  assign bus.pc        = r_pc;
  assign bus.pc_plus4  = w_pc_plus4;
  assign bus.epc       = r_epc;
  assign bus.ras_empty = w_ras_empty;
  assign bus.ras_full  = w_ras_full;
  assign bus.ret_miss  = r_ret_miss;
  assign bus.align_err = r_align_err;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Scoreboard bench for pc_sequencer. A queue-based reference
//                model computes the expected post-edge state for every
//                stimulus cycle; a monitor compares it after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [31:0] c_exc_vec = 32'h8000_0180;
  localparam int          c_depth   = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] plus4;
    logic [31:0] epc;
    logic        empty;
    logic        full;
    logic        miss;
    logic        aerr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0),
    .EXC_VECTOR   (c_exc_vec),
    .RAS_DEPTH    (c_depth)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic        m_miss, m_aerr;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic ras_push(input logic [31:0] a);
    m_ras.push_back(a);
    if (m_ras.size() > c_depth) void'(m_ras.pop_front());
  endtask

  task automatic model_step();
    logic [31:0] p4;
    int          off;
    if (!rst) begin
      m_pc = 32'h0; m_epc = 32'h0; m_ras.delete(); m_miss = 0; m_aerr = 0;
    end else if (bus.exc) begin
      m_epc = m_pc; m_pc = c_exc_vec; m_miss = 0; m_aerr = 0;
    end else if (bus.stall) begin
      m_miss = 0; m_aerr = 0;
    end else begin
      p4 = m_pc + 32'd4;
      m_miss = 0; m_aerr = 0;
      if (bus.ret) begin
        if (m_ras.size() == 0) begin m_pc = p4; m_miss = 1; end
        else m_pc = m_ras.pop_back();
      end else if (bus.jr) begin
        if (bus.call) ras_push(p4);
        m_aerr = (bus.jr_addr % 4) != 0;
        m_pc   = bus.jr_addr - (bus.jr_addr % 4);
      end else if (bus.jump) begin
        if (bus.call) ras_push(p4);
        m_pc = (p4 & 32'hF000_0000) | (32'(bus.jump_target) * 4);
      end else if (bus.br_taken) begin
        off  = int'($signed(bus.br_offset));
        m_pc = p4 + 32'(off * 4);
      end else begin
        m_pc = p4;
      end
    end
  endtask

  // Inputs are set by the caller just after a falling edge; tick predicts the
  // next rising-edge result, queues it, and moves on to the next falling edge.
  task automatic tick();
    exp_t e;
    model_step();
    e.pc = m_pc; e.plus4 = m_pc + 32'd4; e.epc = m_epc;
    e.empty = (m_ras.size() == 0); e.full = (m_ras.size() == c_depth);
    e.miss = m_miss; e.aerr = m_aerr;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic clr();
    rst = 1'b1;
    bus.stall = 0; bus.br_taken = 0; bus.br_offset = '0; bus.jump = 0;
    bus.jump_target = '0; bus.jr = 0; bus.jr_addr = '0; bus.call = 0;
    bus.ret = 0; bus.exc = 0;
  endtask

  task automatic go_to(input logic [31:0] a);
    clr(); bus.jr = 1; bus.jr_addr = a; tick();
  endtask

  // Monitor: compares every queued expectation one step after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",        bus.pc,        e.pc);
        chk("pc_plus4",  bus.pc_plus4,  e.plus4);
        chk("epc",       bus.epc,       e.epc);
        chk("ras_empty", 32'(bus.ras_empty), 32'(e.empty));
        chk("ras_full",  32'(bus.ras_full),  32'(e.full));
        chk("ret_miss",  32'(bus.ret_miss),  32'(e.miss));
        chk("align_err", 32'(bus.align_err), 32'(e.aerr));
      end
    end
  end

  initial begin
    int n;
    clr();
    rst = 1'b0; tick();                       // reset state
    rst = 1'b1;
    repeat (4) tick();                        // 4, 8, 12, 16

    go_to(32'h40); bus.jr = 0; bus.br_taken = 1; bus.br_offset = 16'hFFFE; tick(); // 0x3C
    go_to(32'h40); bus.jr = 0; bus.br_taken = 1; bus.br_offset = 16'd3;    tick(); // 0x50

    go_to(32'h1000_0000);
    clr(); bus.jump = 1; bus.call = 1; bus.jump_target = 26'h100; tick();  // 0x1000_0400
    clr(); bus.ret = 1; tick();                                            // 0x1000_0004

    for (int k = 1; k <= 5; k++) begin        // overfill the RAS
      clr(); bus.jump = 1; bus.call = 1; bus.jump_target = 26'(k * 'h40); tick();
    end
    for (int k = 0; k < 5; k++) begin         // 4 LIFO returns then a miss
      clr(); bus.ret = 1; tick();
    end
    clr(); tick();

    clr(); bus.stall = 1; bus.jump = 1; bus.jump_target = 26'h3FF;
    repeat (3) tick();
    bus.exc = 1; tick();                      // exception wins over stall
    clr(); tick();

    go_to(32'h203); clr(); tick();            // misaligned jr pulse then clear
    clr(); bus.jr = 1; bus.jr_addr = 32'h203; rst = 1'b0; tick();
    clr(); tick();

    go_to(32'hFFFF_FFFC); clr(); tick();      // wrap to 0

    clr(); bus.ret = 1; bus.call = 1; bus.jump = 1; tick(); // ret+call: no push

    for (int i = 0; i < 400; i++) begin
      clr();
      rst             = ($urandom_range(0, 49) != 0);
      bus.exc         = ($urandom_range(0, 19) == 0);
      bus.stall       = ($urandom_range(0, 5) == 0);
      bus.ret         = ($urandom_range(0, 5) == 0);
      bus.jr          = ($urandom_range(0, 7) == 0);
      bus.jump        = ($urandom_range(0, 5) == 0);
      bus.br_taken    = ($urandom_range(0, 3) == 0);
      bus.call        = ($urandom_range(0, 2) == 0);
      bus.br_offset   = 16'($urandom);
      bus.jump_target = 26'($urandom);
      bus.jr_addr     = $urandom;
      tick();
    end

    clr();
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pc_sequencer
`default_nettype wire
